undo_history_ctrl: RTL and testbench

UNDO_HISTORY_CTRL -- requirements
Module: undo_history_ctrl

---
 rtl/undo_history_ctrl.sv | 123 ++++++++++++
 tb/tb_undo_history_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/undo_history_ctrl.sv
// Undo history controller: circular LIFO of game_state snapshots.
// Pushes save a snapshot with no latency; a pop restores the newest snapshot
// one cycle later via a pop_valid pulse, then the controller returns to idle.
// Build option: define HISTORY_OVERWRITE_EN to let a push while full overwrite
// the oldest entry; otherwise such a push is discarded. Either way overflow pulses.
module undo_history_ctrl #(
  parameter int unsigned AW = 3,
  parameter int unsigned W  = 135
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_state,
  input  logic          pop,
  output logic          ready,
  output logic          pop_valid,
  output logic [W-1:0]  pop_state,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] DepthCnt = {1'b1, {AW{1'b0}}};

  typedef enum logic [0:0] {StIdle, StOut} state_e;

  state_e          state_q;
  logic [AW-1:0]   top_q;
  logic [AW:0]     count_q;
  logic [W-1:0]    pop_state_q;
  logic            pop_valid_q;
  logic            overflow_q;
  logic            underflow_q;
  logic [W-1:0]    mem [DEPTH];
  logic            wr_en;

  assign ready     = (state_q == StIdle);
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthCnt);
  assign pop_valid = pop_valid_q;
  assign pop_state = pop_state_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Storage write: only an accepted push in idle with no higher-priority request.
  always_comb begin
    wr_en = 1'b0;
    if (!reset && !clear && (state_q == StIdle) && !pop && push) begin
`ifdef HISTORY_OVERWRITE_EN
      wr_en = 1'b1;
`else
      wr_en = !full;
`endif
    end
  end

  // Snapshot storage; contents are don't-care after reset/clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[top_q] <= push_state;
    end
  end

  // Control FSM, pointers and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      top_q       <= '0;
      count_q     <= '0;
      pop_state_q <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        top_q   <= '0;
        count_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (pop) begin
              if (empty) begin
                underflow_q <= 1'b1;
              end else begin
                top_q       <= top_q - AW'(1);
                count_q     <= count_q - (AW+1)'(1);
                pop_state_q <= mem[top_q - AW'(1)];
                pop_valid_q <= 1'b1;
                state_q     <= StOut;
              end
            end else if (push) begin
              if (!full) begin
                top_q   <= top_q + AW'(1);
                count_q <= count_q + (AW+1)'(1);
              end else begin
                overflow_q <= 1'b1;
`ifdef HISTORY_OVERWRITE_EN
                // Oldest entry is lost; count stays saturated at DEPTH.
                top_q <= top_q + AW'(1);
`endif
              end
            end
          end
          StOut: begin
            // Requests here are ignored; pop_valid is high during this cycle.
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_undo_history_ctrl.sv
// Self-checking bench for undo_history_ctrl with a queue-based reference model
// and a scoreboard of expected pop_state values checked on each pop_valid.
module tb_undo_history_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned W     = 135;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          push;
  logic [W-1:0]  push_state;
  logic          pop;
  logic          ready;
  logic          pop_valid;
  logic [W-1:0]  pop_state;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] stack [$];   // reference history, oldest at front
  logic [W-1:0] sb [$];      // expected pop_state values, in order
  logic [W-1:0] last_popped = '0;

  undo_history_ctrl #(.AW(AW), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .push_state (push_state),
    .pop        (pop),
    .ready      (ready),
    .pop_valid  (pop_valid),
    .pop_state  (pop_state),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every pop_valid must match the next expected snapshot.
  always @(posedge clk) begin
    #1;
    if (pop_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_pop_valid: got pop_valid=1 pop_state=%0h, expected no pop",
                 pop_state);
      end else begin
        logic [W-1:0] exp;
        exp = sb.pop_front();
        if (pop_state !== exp)
          $display("FAIL sb_pop_state: got %0h, expected %0h", pop_state, exp);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  // One clock of stimulus; outputs are settled when this returns.
  task automatic cycle(input logic r, input logic c, input logic p, input logic [W-1:0] d,
                       input logic q);
    @(negedge clk);
    reset = r; clear = c; push = p; push_state = d; pop = q;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic m_push(input logic [W-1:0] v);
    if (stack.size() == DEPTH) begin
`ifdef HISTORY_OVERWRITE_EN
      void'(stack.pop_front());
      stack.push_back(v);
`endif
    end else begin
      stack.push_back(v);
    end
  endtask

  task automatic do_push(input logic [W-1:0] v);
    m_push(v);
    cycle(1'b0, 1'b0, 1'b1, v, 1'b0);
  endtask

  // Pop, then spend the OUT cycle idle.
  task automatic do_pop();
    if (stack.size() != 0) begin
      last_popped = stack.pop_back();
      sb.push_back(last_popped);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle();
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle();
    stack.delete();
    sb.delete();
    last_popped = '0;
    n_checks++;
    if (count !== '0) $display("FAIL reset_count: got %0d, expected 0", count);
    else n_pass++;
    n_checks++;
    if ({ready, empty, full} !== 3'b110)
      $display("FAIL reset_flags: got ready/empty/full=%b, expected 110", {ready, empty, full});
    else n_pass++;
    n_checks++;
    if ({pop_valid, overflow, underflow} !== 3'b000)
      $display("FAIL reset_pulses: got %b, expected 000", {pop_valid, overflow, underflow});
    else n_pass++;
    n_checks++;
    if (pop_state !== '0) $display("FAIL reset_pop_state: got %0h, expected 0", pop_state);
    else n_pass++;
  endtask

  task automatic test_lifo();
    do_push(W'('h11));
    do_push(W'('h22));
    do_push(W'('h33));
    n_checks++;
    if (count !== 4'd3) $display("FAIL lifo_count_after_push: got %0d, expected 3", count);
    else n_pass++;
    for (int i = 2; i >= 0; i--) begin
      do_pop();
      n_checks++;
      if (count !== (AW+1)'(i)) $display("FAIL lifo_count_after_pop: got %0d, expected %0d", count, i);
      else n_pass++;
    end
    n_checks++;
    if (empty !== 1'b1) $display("FAIL lifo_empty: got %b, expected 1", empty);
    else n_pass++;
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if ({underflow, pop_valid, ready} !== 3'b101)
      $display("FAIL underflow_pulse: got underflow/pop_valid/ready=%b, expected 101",
               {underflow, pop_valid, ready});
    else n_pass++;
    n_checks++;
    if (count !== '0) $display("FAIL underflow_count: got %0d, expected 0", count);
    else n_pass++;
    n_checks++;
    if (pop_state !== last_popped)
      $display("FAIL underflow_pop_state_hold: got %0h, expected %0h", pop_state, last_popped);
    else n_pass++;
    idle();
    n_checks++;
    if (underflow !== 1'b0) $display("FAIL underflow_one_cycle: got %b, expected 0", underflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic exp_ovf;
    for (int i = 1; i <= 9; i++) begin
      exp_ovf = (stack.size() == DEPTH);
      do_push(W'(i));
      n_checks++;
      if (overflow !== exp_ovf)
        $display("FAIL overflow_pulse_push%0d: got %b, expected %b", i, overflow, exp_ovf);
      else n_pass++;
    end
    n_checks++;
    if (count !== 4'd8 || full !== 1'b1)
      $display("FAIL overflow_count_full: got count=%0d full=%b, expected 8 1", count, full);
    else n_pass++;
    idle();
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL overflow_one_cycle: got %b, expected 0", overflow);
    else n_pass++;
    for (int i = 0; i < 8; i++) do_pop();
    n_checks++;
    if (empty !== 1'b1 || sb.size() != 0)
      $display("FAIL overflow_drain: got empty=%b pending=%0d, expected 1 0", empty, sb.size());
    else n_pass++;
  endtask

  task automatic test_push_pop_same();
    do_push(W'('hA1));
    do_push(W'('hA2));
    last_popped = stack.pop_back();
    sb.push_back(last_popped);
    cycle(1'b0, 1'b0, 1'b1, W'('hEE), 1'b1);
    idle();
    n_checks++;
    if (count !== 4'd1) $display("FAIL pushpop_count: got %0d, expected 1", count);
    else n_pass++;
    do_pop();
    n_checks++;
    if (count !== '0) $display("FAIL pushpop_drain: got %0d, expected 0", count);
    else n_pass++;
  endtask

  task automatic test_clear_in_out();
    for (int i = 0; i < 4; i++) do_push(W'('hC0 + i));
    last_popped = stack.pop_back();
    sb.push_back(last_popped);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (ready !== 1'b0) $display("FAIL clear_out_ready: got %b, expected 0", ready);
    else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
    stack.delete();
    n_checks++;
    if ({ready, empty} !== 2'b11 || count !== '0)
      $display("FAIL clear_out_state: got ready/empty=%b count=%0d, expected 11 0",
               {ready, empty}, count);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL clear_out_inflight: got pending=%0d, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 5; i++) do_push(W'('hD0 + i));
    cycle(1'b1, 1'b0, 1'b1, W'('hFF), 1'b0);
    stack.delete();
    n_checks++;
    if (count !== '0 || overflow !== 1'b0 || ready !== 1'b1)
      $display("FAIL reset_priority: got count=%0d overflow=%b ready=%b, expected 0 0 1",
               count, overflow, ready);
    else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    do_push(W'('hB1));
    do_push(W'('hB2));
    last_popped = stack.pop_back();
    sb.push_back(last_popped);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    // Second request lands in OUT and must be ignored.
    cycle(1'b0, 1'b0, 1'b1, W'('hEE), 1'b1);
    n_checks++;
    if (count !== 4'd1 || underflow !== 1'b0 || overflow !== 1'b0)
      $display("FAIL b2b_ignored: got count=%0d under=%b over=%b, expected 1 0 0",
               count, underflow, overflow);
    else n_pass++;
    do_pop();
    n_checks++;
    if (count !== '0 || sb.size() != 0)
      $display("FAIL b2b_drain: got count=%0d pending=%0d, expected 0 0", count, sb.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; push_state = '0; pop = 1'b0;
    test_reset();
    test_lifo();
    test_underflow();
    test_overflow();
    test_push_pop_same();
    test_clear_in_out();
    test_reset_priority();
    test_back_to_back();
    idle();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
